// File: rtl/n_bit_serial_add.sv
// rtl/n_bit_serial_add.sv - bit-serial N-bit unsigned adder, LSB first, one full-adder cell
// Optional signed-overflow output ovf is built when ADD_OVF_EN is defined.
module n_bit_serial_add #(
   parameter int Nsize = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [Nsize-1:0] a,
   input  logic [Nsize-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [Nsize-1:0] sum,
   output logic             cout
`ifdef ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (Nsize > 1) ? $clog2(Nsize) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [Nsize-1:0] a_sr;
   logic [Nsize-1:0] b_sr;
   logic [Nsize-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             s_bit;
   logic             c_next;
   logic             last;

   // Single full-adder cell working on the current LSBs
   always_comb begin
      s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
      c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      last   = (cnt == CW'(Nsize - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef ADD_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  sum_sr <= '0;
                  carry  <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sum_sr <= {s_bit, sum_sr[Nsize-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= c_next;
               cnt    <= cnt + 1'b1;
               // Results are published only here, so no partial sum is ever visible
               if (last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= {s_bit, sum_sr[Nsize-1:1]};
                  cout  <= c_next;
`ifdef ADD_OVF_EN
                  ovf   <= carry ^ c_next;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_n_bit_serial_add.sv
// tb/tb_n_bit_serial_add.sv - directed and random self-checking bench for n_bit_serial_add
// Covers ovf only when ADD_OVF_EN is defined.
module tb_n_bit_serial_add;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;
`ifdef ADD_OVF_EN
   logic         ovf;
`endif

   int vectors = 0;
   int miscompares = 0;

   n_bit_serial_add #(.Nsize(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 50) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      start = 1'b1;
      a = 4'd5;
      b = 4'd6;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, sum, cout} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got busy=%0b done=%0b sum=%0d cout=%0b want all 0", busy, done, sum, cout);
      end
`ifdef ADD_OVF_EN
      vectors++;
      if (ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ovf got %0b want 0", ovf);
      end
`endif
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_busy got %0b want 0", busy);
      end
   endtask

   task automatic test_directed;
      logic [N-1:0] va [3];
      logic [N-1:0] vb [3];
      logic [N-1:0] vs [3];
      logic         vc [3];
      logic         vo [3];
      int lat, bc;
      va = '{4'd3, 4'd15, 4'd0};
      vb = '{4'd5, 4'd1,  4'd0};
      vs = '{4'd8, 4'd0,  4'd0};
      vc = '{1'b0, 1'b1,  1'b0};
      vo = '{1'b1, 1'b0,  1'b0};
      for (int i = 0; i < 3; i++) begin
         issue(va[i], vb[i]);
         wait_done(lat, bc);
         vectors++;
         if (lat !== N) begin
            miscompares++;
            $display("FAIL dir%0d_latency got %0d want %0d", i, lat, N);
         end
         vectors++;
         if (bc !== N) begin
            miscompares++;
            $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, N);
         end
         vectors++;
         if ({sum, cout} !== {vs[i], vc[i]}) begin
            miscompares++;
            $display("FAIL dir%0d_sum got sum=%0d cout=%0b want sum=%0d cout=%0b", i, sum, cout, vs[i], vc[i]);
         end
`ifdef ADD_OVF_EN
         vectors++;
         if (ovf !== vo[i]) begin
            miscompares++;
            $display("FAIL dir%0d_ovf got %0b want %0b", i, ovf, vo[i]);
         end
`else
         if (vo[i] === 1'bx) $display("unexpected X in table");
`endif
         @(negedge clk);
         vectors++;
         if ({done, busy, sum, cout} !== {2'b00, vs[i], vc[i]}) begin
            miscompares++;
            $display("FAIL dir%0d_after got done=%0b busy=%0b sum=%0d cout=%0b want done=0 busy=0 sum=%0d cout=%0b",
                     i, done, busy, sum, cout, vs[i], vc[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      @(negedge clk);
      a = 4'd9;
      b = 4'd9;
      start = 1'b1;
      @(negedge clk);
      a = 4'd7;
      b = 4'd2;
      wait_done(lat, bc);
      vectors++;
      if ({sum, cout} !== {4'd2, 1'b1} || lat !== N) begin
         miscompares++;
         $display("FAIL b2b_first got sum=%0d cout=%0b lat=%0d want sum=2 cout=1 lat=%0d", sum, cout, lat, N);
      end
`ifdef ADD_OVF_EN
      vectors++;
      if (ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_ovf got %0b want 1", ovf);
      end
`endif
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({busy, done} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_accept got busy=%0b done=%0b want busy=1 done=0", busy, done);
      end
      wait_done(lat, bc);
      vectors++;
      if (lat + 1 !== N + 1) begin
         miscompares++;
         $display("FAIL b2b_spacing got %0d want %0d", lat + 1, N + 1);
      end
      vectors++;
      if ({sum, cout} !== {4'd9, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_second got sum=%0d cout=%0b want sum=9 cout=0", sum, cout);
      end
`ifdef ADD_OVF_EN
      vectors++;
      if (ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second_ovf got %0b want 1", ovf);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_start_ignored;
      int lat, bc;
      issue(4'd5, 4'd6);
      @(negedge clk);
      a = 4'd1;
      b = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      vectors++;
      if ({sum, cout} !== {4'd11, 1'b0} || lat !== N - 2) begin
         miscompares++;
         $display("FAIL ignore_result got sum=%0d cout=%0b lat=%0d want sum=11 cout=0 lat=%0d", sum, cout, lat, N - 2);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_no_queue got busy=%0b want 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bc;
      issue(4'd7, 4'd7);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, sum, cout} !== '0) begin
         miscompares++;
         $display("FAIL midrst_outputs got busy=%0b done=%0b sum=%0d cout=%0b want all 0", busy, done, sum, cout);
      end
      @(negedge clk);
      rst = 1'b0;
      issue(4'd6, 4'd6);
      wait_done(lat, bc);
      vectors++;
      if ({sum, cout} !== {4'd12, 1'b0} || lat !== N) begin
         miscompares++;
         $display("FAIL midrst_after got sum=%0d cout=%0b lat=%0d want sum=12 cout=0 lat=%0d", sum, cout, lat, N);
      end
`ifdef ADD_OVF_EN
      vectors++;
      if (ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_ovf got %0b want 1", ovf);
      end
`endif
   endtask

   task automatic test_random;
      int lat, bc;
      logic [N-1:0] x, y;
      logic [N:0]   full;
      for (int i = 0; i < 200; i++) begin
         x = N'($urandom_range(0, 15));
         y = N'($urandom_range(0, 15));
         full = {1'b0, x} + {1'b0, y};
         issue(x, y);
         wait_done(lat, bc);
         vectors++;
         if ({sum, cout} !== {full[N-1:0], full[N]} || lat !== N) begin
            miscompares++;
            $display("FAIL rand%0d %0d+%0d got sum=%0d cout=%0b lat=%0d want sum=%0d cout=%0b lat=%0d",
                     i, x, y, sum, cout, lat, full[N-1:0], full[N], N);
         end
`ifdef ADD_OVF_EN
         vectors++;
         if (ovf !== ((x[N-1] == y[N-1]) && (full[N-1] != x[N-1]))) begin
            miscompares++;
            $display("FAIL rand%0d_ovf %0d+%0d got %0b", i, x, y, ovf);
         end
`endif
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_back_to_back;
      test_start_ignored;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
